// File: rtl/mc_ctrl_param_if.sv
// Control bus between mc_ctrl_param and the ARM32 datapath: decoded instruction
// fields and flags in, register/ALU/regfile/RAM enables out.
interface mc_ctrl_param_if;
  logic [6:0]  opcode;
  logic [3:0]  cond;
  logic [31:0] status_reg;
  logic        P;
  logic        U;
  logic        W;
  logic        en_status_decode;

  logic        waiting;
  logic        load_pc;
  logic        load_ir;
  logic [1:0]  sel_pc;
  logic [1:0]  sel_A_in;
  logic [1:0]  sel_B_in;
  logic [1:0]  sel_shift_in;
  logic        en_A;
  logic        en_B;
  logic        en_S;
  logic        en_C;
  logic        sel_A;
  logic        sel_B;
  logic        sel_post_indexing;
  logic [2:0]  ALU_op;
  logic        w_en1;
  logic        w_en2;
  logic        w_en_ldr;
  logic        ram_w_en;
  logic        en_status;
  logic        status_rdy;

  modport master (
    input  opcode, cond, status_reg, P, U, W, en_status_decode,
    output waiting, load_pc, load_ir, sel_pc, sel_A_in, sel_B_in, sel_shift_in,
           en_A, en_B, en_S, en_C, sel_A, sel_B, sel_post_indexing, ALU_op,
           w_en1, w_en2, w_en_ldr, ram_w_en, en_status, status_rdy
  );

  modport slave (
    output opcode, cond, status_reg, P, U, W, en_status_decode,
    input  waiting, load_pc, load_ir, sel_pc, sel_A_in, sel_B_in, sel_shift_in,
           en_A, en_B, en_S, en_C, sel_A, sel_B, sel_post_indexing, ALU_op,
           w_en1, w_en2, w_en_ldr, ram_w_en, en_status, status_rdy
  );
endinterface

// File: rtl/mc_ctrl_param.sv
// Parametrised multicycle ARM32 controller: LOAD_PC/FETCH/DECODE/EXEC/MEMWB/MWAIT/WB_LDR.
// Define CTRL_COND_EXEC_EN to evaluate ARM condition codes at DECODE.
module mc_ctrl_param #(
  parameter int unsigned FETCH_WAIT = 2,
  parameter int unsigned MEM_WAIT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_ctrl_param_if.master   bus
);

  localparam int unsigned FCW = $clog2(FETCH_WAIT + 1);
  localparam int unsigned MCW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [FCW-1:0] F_LOAD = FCW'(FETCH_WAIT);
  localparam logic [MCW-1:0] M_LOAD = MCW'(MEM_WAIT);

  typedef enum logic [2:0] {
    S_RST, S_LOAD_PC, S_FETCH, S_DECODE, S_EXEC, S_MEMWB, S_MWAIT, S_WB_LDR
  } state_t;

  state_t         state, state_nx;
  logic [FCW-1:0] fcnt;
  logic [MCW-1:0] mcnt;
  logic           first_pc;
  logic [6:0]     op_l;
  logic [3:0]     cond_l;
  logic           p_l, u_l, w_l, es_l;
  logic           status_rdy_q;
  logic           cond_pass;

  logic [1:0] mode;
  logic       is_mem;
  logic       is_store;
  assign mode     = op_l[5:4];
  assign is_mem   = op_l[6];
  assign is_store = op_l[3];

`ifdef CTRL_COND_EXEC_EN
  logic f_n, f_z, f_c, f_v;
  assign {f_n, f_z, f_c, f_v} = bus.status_reg[31:28];

  // Evaluated on the live fields during DECODE, i.e. the values being latched.
  always_comb begin
    case (bus.cond)
      4'h0:    cond_pass = f_z;
      4'h1:    cond_pass = !f_z;
      4'h2:    cond_pass = f_c;
      4'h3:    cond_pass = !f_c;
      4'h4:    cond_pass = f_n;
      4'h5:    cond_pass = !f_n;
      4'h6:    cond_pass = f_v;
      4'h7:    cond_pass = !f_v;
      4'h8:    cond_pass = f_c && !f_z;
      4'h9:    cond_pass = !f_c || f_z;
      4'hA:    cond_pass = (f_n == f_v);
      4'hB:    cond_pass = (f_n != f_v);
      4'hC:    cond_pass = !f_z && (f_n == f_v);
      4'hD:    cond_pass = f_z || (f_n != f_v);
      default: cond_pass = 1'b1;
    endcase
  end

  logic unused_sts;
  assign unused_sts = ^{bus.status_reg[27:0], cond_l};
`else
  assign cond_pass = 1'b1;

  logic unused_sts;
  assign unused_sts = ^{bus.status_reg, cond_l};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = S_RST;
    case (state)
      S_RST:     state_nx = S_LOAD_PC;
      S_LOAD_PC: state_nx = S_FETCH;
      S_FETCH:   state_nx = (fcnt == FCW'(1)) ? S_DECODE : S_FETCH;
      S_DECODE:  state_nx = cond_pass ? S_EXEC : S_LOAD_PC;
      S_EXEC:    state_nx = S_MEMWB;
      S_MEMWB: begin
        if (!is_mem)           state_nx = S_LOAD_PC;
        else if (MEM_WAIT > 0) state_nx = S_MWAIT;
        else                   state_nx = is_store ? S_LOAD_PC : S_WB_LDR;
      end
      S_MWAIT: begin
        if (mcnt == MCW'(1)) state_nx = is_store ? S_LOAD_PC : S_WB_LDR;
        else                 state_nx = S_MWAIT;
      end
      S_WB_LDR:  state_nx = S_LOAD_PC;
      default:   state_nx = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt         <= '0;
      mcnt         <= '0;
      first_pc     <= 1'b1;
      op_l         <= '0;
      cond_l       <= '0;
      p_l          <= 1'b0;
      u_l          <= 1'b0;
      w_l          <= 1'b0;
      es_l         <= 1'b0;
      status_rdy_q <= 1'b0;
    end else begin
      if (state_nx == S_LOAD_PC)  fcnt <= F_LOAD;
      else if (state == S_FETCH)  fcnt <= fcnt - FCW'(1);

      if (state == S_MEMWB)       mcnt <= M_LOAD;
      else if (state == S_MWAIT)  mcnt <= mcnt - MCW'(1);

      if (state == S_LOAD_PC) first_pc <= 1'b0;

      if (state == S_DECODE) begin
        op_l   <= bus.opcode;
        cond_l <= bus.cond;
        p_l    <= bus.P;
        u_l    <= bus.U;
        w_l    <= bus.W;
        es_l   <= bus.en_status_decode;
      end

      status_rdy_q <= (state == S_MEMWB) && !is_mem && es_l;
    end
  end

  always_comb begin
    bus.waiting           = 1'b0;
    bus.load_pc           = 1'b0;
    bus.load_ir           = 1'b0;
    bus.sel_pc            = 2'b00;
    bus.sel_A_in          = 2'b00;
    bus.sel_B_in          = 2'b00;
    bus.sel_shift_in      = 2'b00;
    bus.en_A              = 1'b0;
    bus.en_B              = 1'b0;
    bus.en_S              = 1'b0;
    bus.en_C              = 1'b0;
    bus.sel_A             = 1'b0;
    bus.sel_B             = 1'b0;
    bus.sel_post_indexing = 1'b0;
    bus.ALU_op            = 3'b000;
    bus.w_en1             = 1'b0;
    bus.w_en2             = 1'b0;
    bus.w_en_ldr          = 1'b0;
    bus.ram_w_en          = 1'b0;
    bus.en_status         = 1'b0;
    bus.status_rdy        = status_rdy_q;
    case (state)
      S_RST: bus.waiting = 1'b1;
      S_LOAD_PC: begin
        bus.waiting = 1'b1;
        bus.load_pc = 1'b1;
        bus.sel_pc  = first_pc ? 2'b01 : 2'b00;
      end
      S_FETCH: begin
        bus.waiting = 1'b1;
        bus.load_ir = (fcnt == FCW'(1));
      end
      S_EXEC: begin
        bus.en_A         = is_mem || op_l[3];
        bus.en_B         = (mode == 2'b01) || (mode == 2'b11);
        bus.en_S         = (mode == 2'b01) || (mode == 2'b11);
        bus.sel_shift_in = (mode == 2'b11) ? 2'b01 : 2'b00;
        bus.sel_A_in     = (mode == 2'b10) ? 2'b11 : 2'b00;
      end
      S_MEMWB: begin
        bus.sel_B = (mode != 2'b01) && (mode != 2'b11);
        if (!is_mem) begin
          bus.sel_A     = !op_l[3];
          bus.ALU_op    = op_l[2:0];
          bus.w_en1     = 1'b1;
          bus.en_C      = 1'b1;
          bus.en_status = es_l;
        end else begin
          bus.sel_post_indexing = !p_l;
          bus.ALU_op            = u_l ? 3'b000 : 3'b001;
          bus.ram_w_en          = is_store;
          bus.w_en2             = w_l || !p_l;
        end
      end
      S_WB_LDR: bus.w_en_ldr = 1'b1;
      default: ;
    endcase
    // RST is the reset state, so waiting must also be masked while rst_n is held low.
    if (!rst_n) bus.waiting = 1'b0;
  end

endmodule

// File: tb/tb_mc_ctrl_param.sv
// Bench for mc_ctrl_param: two instances (FETCH_WAIT=2/MEM_WAIT=1 and 3/0) checked
// cycle by cycle against a per-instruction timeline model, plus table and reset sequences.
module tb_mc_ctrl_param;

  typedef struct packed {
    logic       waiting, load_pc, load_ir;
    logic [1:0] sel_pc, sel_A_in, sel_B_in, sel_shift_in;
    logic       en_A, en_B, en_S, en_C, sel_A, sel_B, sel_post_indexing;
    logic [2:0] ALU_op;
    logic       w_en1, w_en2, w_en_ldr, ram_w_en, en_status, status_rdy;
  } outs_t;

  typedef struct packed {
    logic [6:0] opcode;
    logic [3:0] cond;
    logic [3:0] nzcv;
    logic       P, U, W, es;
  } instr_t;

  typedef struct {
    string      name;
    int         d;
    instr_t     ins;
    int         len;
    logic [2:0] alu;
    logic [4:0] seen;
  } row_t;

  logic   clk = 1'b0;
  logic   rst_n [2];
  instr_t drv   [2];
  outs_t  act   [2];
  outs_t  expq  [$];
  row_t   rows  [$];
  bit     first [2];
  bit     carry [2];
  int     nvec = 0;
  int     nerr = 0;

  always #5 clk = ~clk;

  mc_ctrl_param_if b0 ();
  mc_ctrl_param_if b1 ();

  mc_ctrl_param #(.FETCH_WAIT(2), .MEM_WAIT(1)) u0 (.clk(clk), .rst_n(rst_n[0]), .bus(b0));
  mc_ctrl_param #(.FETCH_WAIT(3), .MEM_WAIT(0)) u1 (.clk(clk), .rst_n(rst_n[1]), .bus(b1));

  assign b0.opcode = drv[0].opcode;
  assign b0.cond = drv[0].cond;
  assign b0.status_reg = {drv[0].nzcv, 28'h5A5A5A5};
  assign b0.P = drv[0].P;
  assign b0.U = drv[0].U;
  assign b0.W = drv[0].W;
  assign b0.en_status_decode = drv[0].es;
  assign b1.opcode = drv[1].opcode;
  assign b1.cond = drv[1].cond;
  assign b1.status_reg = {drv[1].nzcv, 28'h5A5A5A5};
  assign b1.P = drv[1].P;
  assign b1.U = drv[1].U;
  assign b1.W = drv[1].W;
  assign b1.en_status_decode = drv[1].es;

  assign act[0] = {b0.waiting, b0.load_pc, b0.load_ir, b0.sel_pc, b0.sel_A_in, b0.sel_B_in,
                   b0.sel_shift_in, b0.en_A, b0.en_B, b0.en_S, b0.en_C, b0.sel_A, b0.sel_B,
                   b0.sel_post_indexing, b0.ALU_op, b0.w_en1, b0.w_en2, b0.w_en_ldr,
                   b0.ram_w_en, b0.en_status, b0.status_rdy};
  assign act[1] = {b1.waiting, b1.load_pc, b1.load_ir, b1.sel_pc, b1.sel_A_in, b1.sel_B_in,
                   b1.sel_shift_in, b1.en_A, b1.en_B, b1.en_S, b1.en_C, b1.sel_A, b1.sel_B,
                   b1.sel_post_indexing, b1.ALU_op, b1.w_en1, b1.w_en2, b1.w_en_ldr,
                   b1.ram_w_en, b1.en_status, b1.status_rdy};

  task automatic chk(input string nm, input outs_t a, input outs_t e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %07h expected %07h", nm, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  function automatic bit cond_ok(input instr_t i);
`ifdef CTRL_COND_EXEC_EN
    bit n, z, c, v;
    {n, z, c, v} = i.nzcv;
    case (i.cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
`else
    return (i.cond == i.cond);
`endif
  endfunction

  // Expected timeline of one instruction, from its LOAD_PC cycle to the cycle before the next.
  task automatic build(input int fw, input int mw, input instr_t ins, input bit fst,
                       input bit cry, output bit nxt_carry);
    outs_t      o;
    bit         mem, pass;
    logic [1:0] mode;
    mem  = ins.opcode[6];
    mode = ins.opcode[5:4];
    pass = cond_ok(ins);
    expq.delete();
    o = '0; o.waiting = 1; o.load_pc = 1; o.sel_pc = fst ? 2'b01 : 2'b00; o.status_rdy = cry;
    expq.push_back(o);
    for (int k = 1; k <= fw; k++) begin
      o = '0; o.waiting = 1; o.load_ir = (k == fw);
      expq.push_back(o);
    end
    o = '0;
    expq.push_back(o);
    if (pass) begin
      o = '0;
      o.en_A = mem || ins.opcode[3];
      o.en_B = (mode == 2'b01) || (mode == 2'b11);
      o.en_S = o.en_B;
      o.sel_shift_in = (mode == 2'b11) ? 2'b01 : 2'b00;
      o.sel_A_in = (mode == 2'b10) ? 2'b11 : 2'b00;
      expq.push_back(o);
      o = '0;
      if (!mem) begin
        o.sel_A = !ins.opcode[3];
        o.sel_B = (mode == 2'b00) || (mode == 2'b10);
        o.ALU_op = ins.opcode[2:0];
        o.w_en1 = 1; o.en_C = 1; o.en_status = ins.es;
      end else begin
        o.sel_B = !((mode == 2'b01) || (mode == 2'b11));
        o.sel_post_indexing = !ins.P;
        o.ALU_op = ins.U ? 3'b000 : 3'b001;
        o.ram_w_en = ins.opcode[3];
        o.w_en2 = ins.W || !ins.P;
      end
      expq.push_back(o);
      if (mem) begin
        for (int k = 0; k < mw; k++) begin
          o = '0;
          expq.push_back(o);
        end
        if (!ins.opcode[3]) begin
          o = '0; o.w_en_ldr = 1;
          expq.push_back(o);
        end
      end
    end
    nxt_carry = pass && !mem && ins.es;
  endtask

  task automatic run_instr(input string nm, input int d, input instr_t ins, input int abort_at,
                           output int len_act, output logic [2:0] alu_act, output logic [4:0] seen);
    int         fw, mw;
    bit         nc;
    logic [18:0] r;
    fw = (d == 0) ? 2 : 3;
    mw = (d == 0) ? 1 : 0;
    build(fw, mw, ins, first[d], carry[d], nc);
    len_act = 1; alu_act = '0; seen = '0;
    for (int i = 0; i < expq.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s.c%0d", nm, i), act[d], expq[i]);
      if (i > 0 && !act[d].load_pc) len_act++;
      if (i == fw + 3) alu_act = act[d].ALU_op;
      seen |= {act[d].en_A, act[d].w_en1, act[d].w_en2, act[d].ram_w_en, act[d].w_en_ldr};
      if (i == 0) drv[d] = ins;
      if (i == fw + 2) begin
        r = 19'($urandom);
        drv[d] = r;
      end
      if (i == abort_at) return;
    end
    first[d] = 0;
    carry[d] = nc;
  endtask

  task automatic do_reset(input string nm, input int d);
    outs_t o;
    rst_n[d] = 1'b0;
    #1;
    chk({nm, ".asserted"}, act[d], '0);
    repeat (2) @(posedge clk);
    #1 rst_n[d] = 1'b1;
    @(negedge clk);
    o = '0; o.waiting = 1;
    chk({nm, ".rst_cycle"}, act[d], o);
    first[d] = 1;
    carry[d] = 0;
  endtask

  function automatic instr_t mki(input logic [6:0] op, input logic [3:0] c, input logic [3:0] f,
                                 input logic p, input logic u, input logic w, input logic es);
    instr_t i;
    i.opcode = op; i.cond = c; i.nzcv = f; i.P = p; i.U = u; i.W = w; i.es = es;
    return i;
  endfunction

  task automatic add_row(input string nm, input int d, input instr_t i, input int len,
                         input logic [2:0] alu, input logic [4:0] seen);
    row_t r;
    r.name = nm; r.d = d; r.ins = i; r.len = len; r.alu = alu; r.seen = seen;
    rows.push_back(r);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         len_a;
    logic [2:0] alu_a;
    logic [4:0] seen_a;
    instr_t     ri;
    logic [18:0] r;

    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    drv[0] = '0;
    drv[1] = '0;

    // seen = {en_A, w_en1, w_en2, ram_w_en, w_en_ldr}
    add_row("ADD_R",   0, mki(7'b0011000, 4'hE, 4'h0, 0, 0, 0, 1), 6, 3'b000, 5'b11000);
    add_row("LDR_LIT", 0, mki(7'b1100010, 4'hE, 4'h0, 0, 1, 0, 0), 8, 3'b000, 5'b10101);
    add_row("SUB_IMM", 0, mki(7'b0000010, 4'hE, 4'h0, 0, 0, 0, 1), 6, 3'b010, 5'b01000);
    add_row("STR_R0",  0, mki(7'b1011000, 4'hE, 4'h0, 1, 0, 0, 0), 7, 3'b001, 5'b10010);
`ifdef CTRL_COND_EXEC_EN
    add_row("EQ_Z0",   0, mki(7'b0011000, 4'h0, 4'h0, 0, 0, 0, 1), 4, 3'b000, 5'b00000);
`else
    add_row("EQ_Z0",   0, mki(7'b0011000, 4'h0, 4'h0, 0, 0, 0, 1), 6, 3'b000, 5'b11000);
`endif
    add_row("EQ_Z1",   0, mki(7'b0011000, 4'h0, 4'h4, 0, 0, 0, 1), 6, 3'b000, 5'b11000);
    add_row("LDR_RSR", 0, mki(7'b1110000, 4'hE, 4'h0, 1, 0, 1, 0), 8, 3'b001, 5'b10101);
    add_row("STR_R1",  1, mki(7'b1011000, 4'hE, 4'h0, 1, 0, 0, 0), 7, 3'b001, 5'b10010);
    add_row("LDR_LIT1",1, mki(7'b1100010, 4'hE, 4'h0, 0, 1, 0, 0), 8, 3'b000, 5'b10101);

    for (int d = 0; d < 2; d++) begin
      do_reset($sformatf("reset%0d", d), d);
      foreach (rows[k]) begin
        if (rows[k].d == d) begin
          run_instr(rows[k].name, d, rows[k].ins, -1, len_a, alu_a, seen_a);
          chk_int({rows[k].name, ".len"},  len_a, rows[k].len);
          chk_int({rows[k].name, ".alu"},  int'(alu_a), int'(rows[k].alu));
          chk_int({rows[k].name, ".seen"}, int'(seen_a), int'(rows[k].seen));
        end
      end
      for (int n = 0; n < 30; n++) begin
        r  = 19'($urandom);
        ri = r;
        if ($urandom_range(0, 1) == 0) ri.cond = 4'hE;
        run_instr($sformatf("rnd%0d_%0d", d, n), d, ri, -1, len_a, alu_a, seen_a);
      end
      // Reset pulled in MWAIT (d0) or WB_LDR (d1); the next LOAD_PC must select the start PC.
      run_instr($sformatf("abort%0d", d), d, mki(7'b1100000, 4'hE, 4'h0, 1, 1, 1, 0),
                (d == 0) ? 6 : 7, len_a, alu_a, seen_a);
      do_reset($sformatf("midreset%0d", d), d);
      run_instr($sformatf("after%0d", d), d, mki(7'b0011000, 4'hE, 4'h0, 0, 0, 0, 1), -1,
                len_a, alu_a, seen_a);
      chk_int($sformatf("after%0d.len", d), len_a, (d == 0) ? 6 : 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
